chroni_vram_arbiter: RTL and testbench

Arbitrates the single chroni-side VRAM read port (port B) between three requesters:
- 0: display-list processor
- 1: text/font fetcher
- 2: sprite/blitter fetch

It issues at most one read per cycle. It tracks in-flight reads through a fixed-latency tag pipeline and returns each byte to the requester that issued it. This replaces the per-FSM mem_wait counters and the vram_read_dl address mux in chroni.

---
 rtl/chroni_vram_arbiter_pkg.sv | 20 ++
 rtl/chroni_vram_arbiter_if.sv | 28 ++
 rtl/chroni_tag_pipe.sv | 41 ++++
 rtl/chroni_vram_arbiter.sv | 121 ++++++++++++
 tb/tb_chroni_vram_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/chroni_vram_arbiter_pkg.sv
// Shared requester ids, tag layout and helpers for the chroni VRAM port-B arbiter.
package chroni_vram_arbiter_pkg;

   localparam logic [1:0] REQ_DL     = 2'd0;
   localparam logic [1:0] REQ_TEXT   = 2'd1;
   localparam logic [1:0] REQ_SPRITE = 2'd2;

   localparam int READ_LATENCY_DEF = 2;
   localparam int TAG_ID_W         = 2;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   function automatic logic [2:0] id2oh(input logic [TAG_ID_W-1:0] id);
      return 3'b001 << id;
   endfunction

endpackage

// File: rtl/chroni_vram_arbiter_if.sv
// Requester and VRAM-side signal bundle of the port-B arbiter.
interface chroni_vram_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
);
   logic [2:0]        req;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic              flush;
   logic [2:0]        gnt;
   logic [2:0]        rvalid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rd_data;
   logic              busy;

   modport slave (
      input  req, addr0, addr1, addr2, flush, mem_rd_data,
      output gnt, rvalid, rd_data, mem_addr, mem_rd_en, busy
   );

   modport master (
      output req, addr0, addr1, addr2, flush, mem_rd_data,
      input  gnt, rvalid, rd_data, mem_addr, mem_rd_en, busy
   );
endinterface

// File: rtl/chroni_tag_pipe.sv
// Fixed-depth shift register of read tags; the head stage lines up with returning VRAM data.
module chroni_tag_pipe
   import chroni_vram_arbiter_pkg::*;
#(
   parameter int DEPTH = READ_LATENCY_DEF + 1
) (
   input  logic sys_clk,
   input  logic clr,
   input  tag_t push_tag,
   output tag_t head_tag,
   output logic any_valid
);

   tag_t [DEPTH-1:0] stage_q;
   tag_t [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = push_tag;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      if (clr) begin
         stage_d = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      stage_q <= stage_d;
   end

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_valid = any_valid | stage_q[i].valid;
      end
   end

   assign head_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/chroni_vram_arbiter.sv
// Three-way arbiter for chroni VRAM port B: one read per cycle, in-order return routed by tag.
module chroni_vram_arbiter
   import chroni_vram_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = READ_LATENCY_DEF,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   chroni_vram_arbiter_if.slave  bus
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   logic [2:0]        gnt_q, gnt_d;
   logic [2:0]        rvalid_q, rvalid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [7:0]        starve_q, starve_d;

   logic [2:0]          eff;
   logic                win_valid;
   logic [TAG_ID_W-1:0] win_id;
   tag_t                push_tag, head_tag;
   logic                tags_busy;

   // A requester granted last cycle is masked so a stale req cannot win twice in a row.
   always_comb begin
      eff       = bus.req & ~gnt_q;
      win_valid = 1'b0;
      win_id    = REQ_DL;
      if (starve_q == STARVE_MAX && eff[REQ_SPRITE]) begin
         win_valid = 1'b1;
         win_id    = REQ_SPRITE;
      end else if (eff[REQ_DL]) begin
         win_valid = 1'b1;
         win_id    = REQ_DL;
      end else if (eff[REQ_TEXT]) begin
         win_valid = 1'b1;
         win_id    = REQ_TEXT;
      end else if (eff[REQ_SPRITE]) begin
         win_valid = 1'b1;
         win_id    = REQ_SPRITE;
      end
   end

   always_comb begin
      gnt_d       = 3'b000;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      push_tag    = '0;
      if (win_valid && !bus.flush) begin
         gnt_d       = id2oh(win_id);
         mem_rd_en_d = 1'b1;
         push_tag    = '{valid: 1'b1, id: win_id};
         case (win_id)
            REQ_DL:   mem_addr_d = bus.addr0;
            REQ_TEXT: mem_addr_d = bus.addr1;
            default:  mem_addr_d = bus.addr2;
         endcase
      end
   end

   // A tag reaching the head during flush belongs to an aborted read and is dropped.
   always_comb begin
      rvalid_d  = 3'b000;
      rd_data_d = rd_data_q;
      if (head_tag.valid && !bus.flush) begin
         rvalid_d  = id2oh(head_tag.id);
         rd_data_d = bus.mem_rd_data;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (bus.flush || !bus.req[REQ_SPRITE] || gnt_q[REQ_SPRITE]) begin
         starve_d = 8'd0;
      end else if (!(win_valid && win_id == REQ_SPRITE) && starve_q != STARVE_MAX) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         gnt_q       <= 3'b000;
         rvalid_q    <= 3'b000;
         mem_addr_q  <= '0;
         mem_rd_en_q <= 1'b0;
         rd_data_q   <= '0;
         starve_q    <= 8'd0;
      end else begin
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_en_q <= mem_rd_en_d;
         rd_data_q   <= rd_data_d;
         starve_q    <= starve_d;
      end
   end

   chroni_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .sys_clk   (sys_clk),
      .clr       (reset | bus.flush),
      .push_tag  (push_tag),
      .head_tag  (head_tag),
      .any_valid (tags_busy)
   );

   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd_en = mem_rd_en_q;
   assign bus.busy      = tags_busy | (|gnt_q);

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Directed bench: three arbiter copies (read latency 1, 2, 4) share one requester stimulus.
module tb_chroni_vram_arbiter;

   logic        sys_clk;
   logic        reset;
   logic        flush;
   logic [2:0]  req;
   logic [16:0] addr0, addr1, addr2;

   int n_chk = 0;
   int n_err = 0;

   chroni_vram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus1 ();
   chroni_vram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus2 ();
   chroni_vram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus4 ();

   chroni_vram_arbiter #(.READ_LATENCY(1)) u_dut1 (.sys_clk(sys_clk), .reset(reset), .bus(bus1));
   chroni_vram_arbiter #(.READ_LATENCY(2)) u_dut2 (.sys_clk(sys_clk), .reset(reset), .bus(bus2));
   chroni_vram_arbiter #(.READ_LATENCY(4)) u_dut4 (.sys_clk(sys_clk), .reset(reset), .bus(bus4));

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [7:0] memf(input logic [16:0] a);
      return (a == 17'h1d05) ? 8'hA7 : a[7:0];
   endfunction

   // VRAM models: the address presented in cycle G is answered in cycle G+latency.
   logic [16:0]      h1;
   logic [1:0][16:0] h2;
   logic [3:0][16:0] h4;
   always @(posedge sys_clk) begin
      h1 <= bus1.mem_addr;
      h2 <= {h2[0], bus2.mem_addr};
      h4 <= {h4[2:0], bus4.mem_addr};
   end

   assign bus1.req = req;   assign bus2.req = req;   assign bus4.req = req;
   assign bus1.addr0 = addr0; assign bus2.addr0 = addr0; assign bus4.addr0 = addr0;
   assign bus1.addr1 = addr1; assign bus2.addr1 = addr1; assign bus4.addr1 = addr1;
   assign bus1.addr2 = addr2; assign bus2.addr2 = addr2; assign bus4.addr2 = addr2;
   assign bus1.flush = flush; assign bus2.flush = flush; assign bus4.flush = flush;
   assign bus1.mem_rd_data = memf(h1);
   assign bus2.mem_rd_data = memf(h2[1]);
   assign bus4.mem_rd_data = memf(h4[3]);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] cont_data(input logic [2:0] g);
      case (g)
         3'b001:  return 8'h11;
         3'b010:  return 8'h22;
         3'b100:  return 8'h33;
         default: return 8'h00;
      endcase
   endfunction

   logic [2:0] exp_g [0:20];
   int exp_idx, n_issue, n_r0, n_extra, cyc;

   initial begin
      reset = 1'b1; flush = 1'b0; req = 3'b111;
      addr0 = 17'h111; addr1 = 17'h122; addr2 = 17'h133;
      for (int i = 0; i <= 20; i++) exp_g[i] = 3'b000;

      // reset held with all requests pending
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         chk("rst_gnt",    32'(bus2.gnt),       32'h0);
         chk("rst_rvalid", 32'(bus2.rvalid),    32'h0);
         chk("rst_rd_en",  32'(bus2.mem_rd_en), 32'h0);
         chk("rst_addr",   32'(bus2.mem_addr),  32'h0);
         chk("rst_busy",   32'(bus2.busy),      32'h0);
      end
      reset = 1'b0;

      // contention: 0/1 alternate, 2 wins once after 15 lost cycles
      for (int c = 1; c <= 20; c++) begin
         @(negedge sys_clk);
         exp_g[c] = (c == 16) ? 3'b100 : ((c % 2) == 1) ? 3'b001 : 3'b010;
         chk("cont_gnt", 32'(bus2.gnt), 32'(exp_g[c]));
         chk("cont_rd_en", 32'(bus2.mem_rd_en), 32'h1);
         if (c == 16) chk("cont_addr2", 32'(bus2.mem_addr), 32'h133);
         if (c >= 3) chk("cont_rv_l1", 32'(bus1.rvalid), 32'(exp_g[c-2]));
         if (c >= 4) begin
            chk("cont_rv_l2", 32'(bus2.rvalid), 32'(exp_g[c-3]));
            chk("cont_data_l2", 32'(bus2.rd_data), 32'(cont_data(exp_g[c-3])));
         end
         if (c >= 6) chk("cont_rv_l4", 32'(bus4.rvalid), 32'(exp_g[c-5]));
      end
      req = 3'b000;
      repeat (8) @(negedge sys_clk);
      chk("idle_busy", 32'(bus2.busy), 32'h0);

      // single read on all three latencies
      req = 3'b010; addr1 = 17'h1d05;
      @(negedge sys_clk);
      chk("sr_gnt",   32'(bus2.gnt),       32'h2);
      chk("sr_addr",  32'(bus2.mem_addr),  32'h1d05);
      chk("sr_rd_en", 32'(bus2.mem_rd_en), 32'h1);
      chk("sr_busy",  32'(bus2.busy),      32'h1);
      chk("sr_gnt_l1", 32'(bus1.gnt), 32'h2);
      chk("sr_gnt_l4", 32'(bus4.gnt), 32'h2);
      req = 3'b000;
      for (int k = 1; k <= 6; k++) begin
         @(negedge sys_clk);
         chk("sr_rv_l1", 32'(bus1.rvalid), (k == 2) ? 32'h2 : 32'h0);
         chk("sr_rv_l2", 32'(bus2.rvalid), (k == 3) ? 32'h2 : 32'h0);
         chk("sr_rv_l4", 32'(bus4.rvalid), (k == 5) ? 32'h2 : 32'h0);
         if (k == 2) chk("sr_data_l1", 32'(bus1.rd_data), 32'hA7);
         if (k == 3) chk("sr_data_l2", 32'(bus2.rd_data), 32'hA7);
         if (k == 5) chk("sr_data_l4", 32'(bus4.rd_data), 32'hA7);
      end

      // requester 1 streams 80 reads, requester 0 cuts in once
      exp_idx = 0; n_issue = 0; n_r0 = 0; n_extra = 0; cyc = 0;
      req = 3'b010; addr1 = 17'h0;
      while (cyc < 400 && !(exp_idx >= 80 && n_r0 >= 1)) begin
         @(negedge sys_clk);
         if (bus2.rvalid[1]) begin
            chk("strm_data", 32'(bus2.rd_data), 32'(exp_idx & 255));
            exp_idx++;
         end
         if (bus2.rvalid[0]) begin
            chk("strm_r0_data", 32'(bus2.rd_data), 32'hAA);
            n_r0++;
         end
         if (bus2.gnt[1]) begin
            n_issue++;
            if (n_issue >= 80) req[1] = 1'b0;
            else addr1 = 17'(n_issue);
         end
         if (bus2.gnt[0]) req[0] = 1'b0;
         if (cyc == 10) begin
            req[0] = 1'b1; addr0 = 17'h0AA;
         end
         cyc++;
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge sys_clk);
         if (bus2.rvalid != 3'b000) n_extra++;
      end
      chk("strm_cnt1",  32'(exp_idx), 32'd80);
      chk("strm_cnt0",  32'(n_r0),    32'd1);
      chk("strm_extra", 32'(n_extra), 32'd0);

      // flush one cycle after a grant
      req = 3'b000;
      repeat (4) @(negedge sys_clk);
      req = 3'b010; addr1 = 17'h00010;
      @(negedge sys_clk);
      chk("fl_gnt", 32'(bus2.gnt), 32'h2);
      req = 3'b000;
      @(negedge sys_clk);
      flush = 1'b1; req = 3'b001; addr0 = 17'h55;
      @(negedge sys_clk);
      chk("fl_no_gnt",   32'(bus2.gnt),       32'h0);
      chk("fl_no_rd_en", 32'(bus2.mem_rd_en), 32'h0);
      chk("fl_busy",     32'(bus2.busy),      32'h0);
      chk("fl_rv_l1",    32'(bus1.rvalid),    32'h0);
      flush = 1'b0; req = 3'b000;
      for (int k = 3; k <= 6; k++) begin
         @(negedge sys_clk);
         chk("fl_rv_l2", 32'(bus2.rvalid), 32'h0);
         chk("fl_rv_l4", 32'(bus4.rvalid), 32'h0);
         chk("fl_gnt_after", 32'(bus2.gnt), 32'h0);
      end

      // arbitration resumes after flush
      req = 3'b001; addr0 = 17'h55;
      @(negedge sys_clk);
      chk("rs_gnt", 32'(bus2.gnt), 32'h1);
      req = 3'b000;
      repeat (2) @(negedge sys_clk);
      @(negedge sys_clk);
      chk("rs_rv",   32'(bus2.rvalid),  32'h1);
      chk("rs_data", 32'(bus2.rd_data), 32'h55);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
